// File: rtl/vproc_pkg.sv
// ----------------------------------------------------------------------------
// vproc_pkg
// Shared types for the XIF result sink: the tracker entry layout and the
// RUN/HALT control state. The entry ID field is sized for the widest
// supported XIF ID. Narrower IDs are zero-extended on entry, so one struct
// serves every XIF_ID_W up to TRK_ID_W.
// ----------------------------------------------------------------------------
package vproc_pkg;

    localparam int unsigned TRK_ID_W = 8;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } sink_state_e;

    typedef struct packed {
        logic                valid;
        logic [TRK_ID_W-1:0] id;
        logic                wb;
        logic                committed;
        logic                killed;
    } trk_entry_t;

endpackage

// File: rtl/vproc_xif_result_sink_if.sv
// ----------------------------------------------------------------------------
// vproc_xif_result_sink_if
// XIF result channel, from the coprocessor to the scalar core.
//   master : coprocessor side; drives valid/id/data/rd/we/exc/exccode.
//   slave  : core side; drives ready.
// ----------------------------------------------------------------------------
interface vproc_xif_result_sink_if #(
    parameter int unsigned XIF_ID_W = 3
) ();
    logic                valid;
    logic                ready;
    logic [XIF_ID_W-1:0] id;
    logic [31:0]         data;
    logic [4:0]          rd;
    logic                we;
    logic                exc;
    logic [5:0]          exccode;

    modport master (
        output valid, id, data, rd, we, exc, exccode,
        input  ready
    );

    modport slave (
        input  valid, id, data, rd, we, exc, exccode,
        output ready
    );
endinterface

// File: rtl/vproc_wb_reg.sv
// ----------------------------------------------------------------------------
// vproc_wb_reg
// One-entry valid/ready register between the result channel and the scalar
// register-file write port. The register can take a new value in the same
// cycle the old one drains, so a steady stream of writes runs at full rate.
//   clk_i, async_rst_ni : clock, asynchronous active-low reset
//   clear_i             : drop any pending write (pipeline flush)
//   in_*                : load side (valid/ready, rd, data)
//   out_*               : register-file side (valid/ready, rd, data)
// ----------------------------------------------------------------------------
module vproc_wb_reg #(
    parameter bit DONT_CARE_ZERO = 1'b0
) (
    input  logic        clk_i,
    input  logic        async_rst_ni,
    input  logic        clear_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [4:0]  in_rd_i,
    input  logic [31:0] in_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [4:0]  out_rd_o,
    output logic [31:0] out_data_o
);
    localparam logic [4:0]  RD_RST   = DONT_CARE_ZERO ? '0 : 'x;
    localparam logic [31:0] DATA_RST = DONT_CARE_ZERO ? '0 : 'x;

    logic        r_valid;
    logic [4:0]  r_rd;
    logic [31:0] r_data;
    logic        w_load;

    assign in_ready_o = ~r_valid | out_ready_i;
    assign w_load     = in_valid_i & in_ready_o;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge value of the others, whatever the order
    // of the always blocks.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            r_valid <= 1'b0;
        end else if (clear_i) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
        end else if (out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    // NOTE: the payload is qualified by r_valid, so its reset value carries no
    // meaning; it is reset only to pick zero or 'x on the outputs.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            r_rd   <= RD_RST;
            r_data <= DATA_RST;
        end else if (w_load) begin
            r_rd   <= in_rd_i;
            r_data <= in_data_i;
        end
    end

    assign out_valid_o = r_valid;
    assign out_rd_o    = r_rd;
    assign out_data_o  = r_data;
endmodule

// File: rtl/vproc_xif_result_sink.sv
// ----------------------------------------------------------------------------
// vproc_xif_result_sink
// Core-side receiver for the XIF result channel. It tracks every offloaded
// instruction from issue to commit or kill, accepts results strictly in issue
// order, forwards register writes through a one-entry writeback register and
// pulses exceptions to the pipeline. After an exception it halts until a
// pipeline flush.
//   clk_i, async_rst_ni          : clock, asynchronous active-low reset
//   issue_* / issue_ready_o      : new offloaded instruction
//   commit_*                     : commit or kill of a tracked ID
//   result_if (slave)            : coprocessor result channel
//   wb_*                         : register-file write port
//   exc_*                        : one-cycle exception report
//   flush_i                      : clears tracking state, leaves HALT
//   outstanding_o, proto_err_o   : occupancy, sticky protocol error
// ----------------------------------------------------------------------------
module vproc_xif_result_sink
    import vproc_pkg::*;
#(
    parameter int unsigned XIF_ID_W       = 3,
    parameter int unsigned DEPTH          = 4,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       async_rst_ni,
    input  logic                       issue_fire_i,
    output logic                       issue_ready_o,
    input  logic [XIF_ID_W-1:0]        issue_id_i,
    input  logic                       issue_wb_i,
    input  logic                       commit_valid_i,
    input  logic [XIF_ID_W-1:0]        commit_id_i,
    input  logic                       commit_kill_i,
    vproc_xif_result_sink_if.slave     result_if,
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    output logic [4:0]                 wb_rd_o,
    output logic [31:0]                wb_data_o,
    output logic                       exc_valid_o,
    output logic [XIF_ID_W-1:0]        exc_id_o,
    output logic [5:0]                 exc_code_o,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
    output logic                       proto_err_o
);
    localparam int unsigned        PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned        CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DEPTH);
    localparam logic [XIF_ID_W-1:0] EXC_ID_RST   = DONT_CARE_ZERO ? '0 : 'x;
    localparam logic [5:0]          EXC_CODE_RST = DONT_CARE_ZERO ? '0 : 'x;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    trk_entry_t          r_trk [DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;
    sink_state_e         r_state;
    logic                r_proto_err;
    logic                r_exc_valid;
    logic [XIF_ID_W-1:0] r_exc_id;
    logic [5:0]          r_exc_code;

    trk_entry_t          w_head;
    logic [DEPTH-1:0]    w_commit_hit;
    logic [DEPTH-1:0]    w_result_hit;
    logic                w_full;
    logic                w_head_match;
    logic                w_wb_in_ready;
    logic                w_accept;
    logic                w_retire;
    logic                w_pop;
    logic                w_push;
    logic                w_wb_load;
    logic                w_proto_evt;

    assign w_head = r_trk[r_head];
    assign w_full = (r_count == CNT_FULL);

    // Associative lookup of the commit and result IDs over all valid entries.
    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_commit_hit = '0;
        w_result_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_commit_hit[i] = r_trk[i].valid && (r_trk[i].id == TRK_ID_W'(commit_id_i));
            w_result_hit[i] = r_trk[i].valid && (r_trk[i].id == TRK_ID_W'(result_if.id));
        end
    end

    // Only the head may deliver a result, and only once it is committed.
    // Issue, commit and flush inputs of the same cycle do not reach ready.
    assign w_head_match = w_head.valid & w_head.committed & ~w_head.killed &
                          (w_head.id == TRK_ID_W'(result_if.id));
    assign w_accept     = (r_state == RUN) & result_if.valid & w_head_match & w_wb_in_ready;
    assign result_if.ready = w_accept;

    // A killed head never gets a result; retire it on its own. This is
    // mutually exclusive with an accept because an accept needs ~killed.
    assign w_retire  = w_head.valid & w_head.killed;
    assign w_pop     = w_accept | w_retire;
    assign w_push    = issue_fire_i & ~w_full;
    assign w_wb_load = w_accept & result_if.we & w_head.wb & ~result_if.exc;

    assign w_proto_evt = (issue_fire_i & w_full) |
                         (commit_valid_i & ~|w_commit_hit) |
                         (result_if.valid & ~|w_result_hit) |
                         (w_accept & result_if.we & ~w_head.wb);

    // Tracker, pointers, counter and control state. Commit flags are applied
    // first and the pop then clears the head's valid bit, so an entry leaving
    // the queue this cycle cannot be revived by a late commit.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            r_trk   <= '{default: '0};
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_state <= RUN;
        end else if (flush_i) begin
            r_trk   <= '{default: '0};
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_state <= RUN;
        end else begin
            if (commit_valid_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_commit_hit[i]) begin
                        if (commit_kill_i) r_trk[i].killed    <= 1'b1;
                        else               r_trk[i].committed <= 1'b1;
                    end
                end
            end
            if (w_pop) begin
                r_trk[r_head].valid <= 1'b0;
                r_head              <= ptr_inc(r_head);
            end
            if (w_push) begin
                r_trk[r_tail] <= '{valid: 1'b1, id: TRK_ID_W'(issue_id_i),
                                   wb: issue_wb_i, committed: 1'b0, killed: 1'b0};
                r_tail        <= ptr_inc(r_tail);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_accept && result_if.exc) r_state <= HALT;
        end
    end

    // Exception report and sticky error; neither is touched by flush_i.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            r_exc_valid <= 1'b0;
            r_exc_id    <= EXC_ID_RST;
            r_exc_code  <= EXC_CODE_RST;
            r_proto_err <= 1'b0;
        end else begin
            r_exc_valid <= w_accept & result_if.exc;
            if (w_accept && result_if.exc) begin
                r_exc_id   <= result_if.id;
                r_exc_code <= result_if.exccode;
            end
            r_proto_err <= r_proto_err | w_proto_evt;
        end
    end

    vproc_wb_reg #(
        .DONT_CARE_ZERO (DONT_CARE_ZERO)
    ) u_wb_reg (
        .clk_i        (clk_i),
        .async_rst_ni (async_rst_ni),
        .clear_i      (flush_i),
        .in_valid_i   (w_wb_load),
        .in_ready_o   (w_wb_in_ready),
        .in_rd_i      (result_if.rd),
        .in_data_i    (result_if.data),
        .out_valid_o  (wb_valid_o),
        .out_ready_i  (wb_ready_i),
        .out_rd_o     (wb_rd_o),
        .out_data_o   (wb_data_o)
    );

    assign issue_ready_o = ~w_full;
    assign outstanding_o = r_count;
    assign proto_err_o   = r_proto_err;
    assign exc_valid_o   = r_exc_valid;
    assign exc_id_o      = r_exc_id;
    assign exc_code_o    = r_exc_code;
endmodule

// File: tb/tb_vproc_xif_result_sink.sv
// ----------------------------------------------------------------------------
// tb_vproc_xif_result_sink
// Directed bench for the XIF result sink. Inputs change 1 ns after a rising
// edge; registered outputs are sampled there, combinational ready 1 ns later.
// ----------------------------------------------------------------------------
module tb_vproc_xif_result_sink;
    logic        clk_i = 1'b0;
    logic        async_rst_ni = 1'b0;
    logic        issue_fire_i = 1'b0;
    logic        issue_ready_o;
    logic [2:0]  issue_id_i = '0;
    logic        issue_wb_i = 1'b0;
    logic        commit_valid_i = 1'b0;
    logic [2:0]  commit_id_i = '0;
    logic        commit_kill_i = 1'b0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b0;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        exc_valid_o;
    logic [2:0]  exc_id_o;
    logic [5:0]  exc_code_o;
    logic        flush_i = 1'b0;
    logic [2:0]  outstanding_o;
    logic        proto_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    vproc_xif_result_sink_if #(.XIF_ID_W(3)) rif ();

    vproc_xif_result_sink #(
        .XIF_ID_W       (3),
        .DEPTH          (4),
        .DONT_CARE_ZERO (1'b1)
    ) dut (
        .clk_i          (clk_i),
        .async_rst_ni   (async_rst_ni),
        .issue_fire_i   (issue_fire_i),
        .issue_ready_o  (issue_ready_o),
        .issue_id_i     (issue_id_i),
        .issue_wb_i     (issue_wb_i),
        .commit_valid_i (commit_valid_i),
        .commit_id_i    (commit_id_i),
        .commit_kill_i  (commit_kill_i),
        .result_if      (rif.slave),
        .wb_valid_o     (wb_valid_o),
        .wb_ready_i     (wb_ready_i),
        .wb_rd_o        (wb_rd_o),
        .wb_data_o      (wb_data_o),
        .exc_valid_o    (exc_valid_o),
        .exc_id_o       (exc_id_o),
        .exc_code_o     (exc_code_o),
        .flush_i        (flush_i),
        .outstanding_o  (outstanding_o),
        .proto_err_o    (proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [2:0] id, input logic wb);
        issue_fire_i = 1'b1; issue_id_i = id; issue_wb_i = wb;
        tick();
        issue_fire_i = 1'b0;
    endtask

    task automatic commit(input logic [2:0] id, input logic kill);
        commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
        tick();
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    endtask

    task automatic set_result(input logic [2:0] id, input logic [31:0] data,
                              input logic [4:0] rd, input logic we,
                              input logic exc, input logic [5:0] code);
        rif.valid = 1'b1; rif.id = id; rif.data = data; rif.rd = rd;
        rif.we = we; rif.exc = exc; rif.exccode = code;
    endtask

    task automatic clear_result();
        rif.valid = 1'b0; rif.we = 1'b0; rif.exc = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready: got %b expected 1", issue_ready_o); end
        n_checks++; if (rif.ready !== 1'b0) begin n_fail++; $display("FAIL reset_result_ready: got %b expected 0", rif.ready); end
        n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid_o); end
        n_checks++; if (exc_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_exc_valid: got %b expected 0", exc_valid_o); end
        n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding_o); end
        n_checks++; if (proto_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b expected 0", proto_err_o); end
        n_checks++; if ({wb_rd_o, wb_data_o, exc_id_o, exc_code_o} !== '0) begin n_fail++; $display("FAIL reset_dont_care_zero: got %h expected 0", {wb_rd_o, wb_data_o, exc_id_o, exc_code_o}); end
    endtask

    task automatic test_in_order();
        logic [31:0] exp_data;
        wb_ready_i = 1'b1;
        issue(3'd0, 1'b1); issue(3'd1, 1'b1); issue(3'd2, 1'b1);
        n_checks++; if (outstanding_o !== 3'd3) begin n_fail++; $display("FAIL inorder_outstanding3: got %0d expected 3", outstanding_o); end
        commit(3'd0, 1'b0); commit(3'd1, 1'b0); commit(3'd2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            exp_data = 32'hA000_0000 + 32'(k);
            set_result(3'(k), exp_data, 5'(k + 1), 1'b1, 1'b0, 6'd0);
            #1;
            n_checks++; if (rif.ready !== 1'b1) begin n_fail++; $display("FAIL inorder_ready[%0d]: got %b expected 1", k, rif.ready); end
            tick();
            n_checks++; if (wb_valid_o !== 1'b1 || wb_data_o !== exp_data || wb_rd_o !== 5'(k + 1))
                begin n_fail++; $display("FAIL inorder_write[%0d]: got v=%b rd=%0d d=%h expected v=1 rd=%0d d=%h", k, wb_valid_o, wb_rd_o, wb_data_o, k + 1, exp_data); end
            n_checks++; if (outstanding_o !== 3'(2 - k)) begin n_fail++; $display("FAIL inorder_outstanding[%0d]: got %0d expected %0d", k, outstanding_o, 2 - k); end
        end
        clear_result();
        tick();
        n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL inorder_drain: got %b expected 0", wb_valid_o); end
    endtask

    task automatic test_out_of_order();
        issue(3'd3, 1'b1); issue(3'd4, 1'b1);
        commit(3'd3, 1'b0); commit(3'd4, 1'b0);
        set_result(3'd4, 32'h4444_0004, 5'd4, 1'b1, 1'b0, 6'd0);
        #1;
        n_checks++; if (rif.ready !== 1'b0) begin n_fail++; $display("FAIL ooo_wait_ready: got %b expected 0", rif.ready); end
        tick(); #1;
        n_checks++; if (rif.ready !== 1'b0 || proto_err_o !== 1'b0) begin n_fail++; $display("FAIL ooo_still_waiting: got ready=%b err=%b expected 0/0", rif.ready, proto_err_o); end
        set_result(3'd3, 32'h3333_0003, 5'd3, 1'b1, 1'b0, 6'd0);
        #1;
        n_checks++; if (rif.ready !== 1'b1) begin n_fail++; $display("FAIL ooo_ready3: got %b expected 1", rif.ready); end
        tick();
        n_checks++; if (wb_data_o !== 32'h3333_0003) begin n_fail++; $display("FAIL ooo_data3: got %h expected 33330003", wb_data_o); end
        set_result(3'd4, 32'h4444_0004, 5'd4, 1'b1, 1'b0, 6'd0);
        #1;
        n_checks++; if (rif.ready !== 1'b1) begin n_fail++; $display("FAIL ooo_ready4: got %b expected 1", rif.ready); end
        tick();
        n_checks++; if (wb_data_o !== 32'h4444_0004 || outstanding_o !== 3'd0) begin n_fail++; $display("FAIL ooo_data4: got d=%h out=%0d expected 44440004/0", wb_data_o, outstanding_o); end
        clear_result();
        tick();
    endtask

    task automatic test_kill();
        int waited = 0;
        issue(3'd5, 1'b1); issue(3'd6, 1'b1); issue(3'd7, 1'b1);
        commit(3'd6, 1'b1); commit(3'd5, 1'b0); commit(3'd7, 1'b0);
        set_result(3'd5, 32'h5555_0005, 5'd5, 1'b1, 1'b0, 6'd0);
        #1;
        n_checks++; if (rif.ready !== 1'b1) begin n_fail++; $display("FAIL kill_ready5: got %b expected 1", rif.ready); end
        tick();
        set_result(3'd7, 32'h7777_0007, 5'd7, 1'b1, 1'b0, 6'd0);
        #1;
        while (rif.ready !== 1'b1 && waited < 4) begin
            tick(); #1;
            waited++;
        end
        n_checks++; if (waited != 1) begin n_fail++; $display("FAIL kill_retire_cycles: got %0d expected 1", waited); end
        tick();
        n_checks++; if (wb_data_o !== 32'h7777_0007 || outstanding_o !== 3'd0 || proto_err_o !== 1'b0)
            begin n_fail++; $display("FAIL kill_final: got d=%h out=%0d err=%b expected 77770007/0/0", wb_data_o, outstanding_o, proto_err_o); end
        clear_result();
        tick();
    endtask

    task automatic test_exception();
        issue(3'd2, 1'b1);
        commit(3'd2, 1'b0);
        set_result(3'd2, 32'hDEAD_BEEF, 5'd9, 1'b1, 1'b1, 6'h0D);
        #1;
        n_checks++; if (rif.ready !== 1'b1) begin n_fail++; $display("FAIL exc_ready: got %b expected 1", rif.ready); end
        tick();
        clear_result();
        n_checks++; if (exc_valid_o !== 1'b1 || exc_id_o !== 3'd2 || exc_code_o !== 6'h0D)
            begin n_fail++; $display("FAIL exc_pulse: got v=%b id=%0d code=%h expected 1/2/0d", exc_valid_o, exc_id_o, exc_code_o); end
        n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL exc_no_write: got %b expected 0", wb_valid_o); end
        tick();
        n_checks++; if (exc_valid_o !== 1'b0) begin n_fail++; $display("FAIL exc_one_cycle: got %b expected 0", exc_valid_o); end
        issue(3'd3, 1'b1);
        commit(3'd3, 1'b0);
        set_result(3'd3, 32'h0000_0333, 5'd3, 1'b1, 1'b0, 6'd0);
        #1;
        n_checks++; if (rif.ready !== 1'b0) begin n_fail++; $display("FAIL halt_stall: got %b expected 0", rif.ready); end
        tick(); tick(); #1;
        n_checks++; if (rif.ready !== 1'b0) begin n_fail++; $display("FAIL halt_stall_held: got %b expected 0", rif.ready); end
        clear_result();
        flush_i = 1'b1; issue_fire_i = 1'b1; issue_id_i = 3'd5; issue_wb_i = 1'b1;
        tick();
        flush_i = 1'b0; issue_fire_i = 1'b0;
        n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL flush_drops_issue: got %0d expected 0", outstanding_o); end
        issue(3'd3, 1'b1);
        commit(3'd3, 1'b0);
        set_result(3'd3, 32'h0000_0333, 5'd3, 1'b1, 1'b0, 6'd0);
        #1;
        n_checks++; if (rif.ready !== 1'b1) begin n_fail++; $display("FAIL flush_resume_ready: got %b expected 1", rif.ready); end
        tick();
        clear_result();
        n_checks++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h0000_0333 || proto_err_o !== 1'b0)
            begin n_fail++; $display("FAIL flush_resume_write: got v=%b d=%h err=%b expected 1/00000333/0", wb_valid_o, wb_data_o, proto_err_o); end
        tick();
    endtask

    task automatic test_full_backpressure();
        for (int k = 0; k < 4; k++) issue(3'(k), 1'b1);
        n_checks++; if (issue_ready_o !== 1'b0 || outstanding_o !== 3'd4) begin n_fail++; $display("FAIL full_flags: got ready=%b out=%0d expected 0/4", issue_ready_o, outstanding_o); end
        for (int k = 0; k < 4; k++) commit(3'(k), 1'b0);
        wb_ready_i = 1'b0;
        set_result(3'd0, 32'hB000_0000, 5'd10, 1'b1, 1'b0, 6'd0);
        #1;
        n_checks++; if (rif.ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready0: got %b expected 1", rif.ready); end
        tick();
        n_checks++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'hB000_0000 || issue_ready_o !== 1'b1)
            begin n_fail++; $display("FAIL bp_first_write: got v=%b d=%h ir=%b expected 1/b0000000/1", wb_valid_o, wb_data_o, issue_ready_o); end
        set_result(3'd1, 32'hB000_0001, 5'd11, 1'b1, 1'b0, 6'd0);
        #1;
        n_checks++; if (rif.ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got %b expected 0", rif.ready); end
        tick(); #1;
        n_checks++; if (rif.ready !== 1'b0 || wb_data_o !== 32'hB000_0000) begin n_fail++; $display("FAIL bp_hold: got ready=%b d=%h expected 0/b0000000", rif.ready, wb_data_o); end
        wb_ready_i = 1'b1;
        #1;
        n_checks++; if (rif.ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b expected 1", rif.ready); end
        tick();
        n_checks++; if (wb_data_o !== 32'hB000_0001) begin n_fail++; $display("FAIL bp_data1: got %h expected b0000001", wb_data_o); end
        for (int k = 2; k < 4; k++) begin
            set_result(3'(k), 32'hB000_0000 + 32'(k), 5'(10 + k), 1'b1, 1'b0, 6'd0);
            tick();
        end
        clear_result();
        n_checks++; if (wb_data_o !== 32'hB000_0003 || outstanding_o !== 3'd0) begin n_fail++; $display("FAIL bp_drain: got d=%h out=%0d expected b0000003/0", wb_data_o, outstanding_o); end
        tick();
        n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b expected 0", wb_valid_o); end
    endtask

    task automatic test_proto_err_and_reset();
        set_result(3'd7, 32'h0, 5'd1, 1'b1, 1'b0, 6'd0);
        #1;
        n_checks++; if (rif.ready !== 1'b0) begin n_fail++; $display("FAIL untracked_ready: got %b expected 0", rif.ready); end
        tick();
        clear_result();
        n_checks++; if (proto_err_o !== 1'b1) begin n_fail++; $display("FAIL untracked_err: got %b expected 1", proto_err_o); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_checks++; if (proto_err_o !== 1'b1) begin n_fail++; $display("FAIL err_survives_flush: got %b expected 1", proto_err_o); end
        issue(3'd1, 1'b1);
        commit(3'd1, 1'b0);
        wb_ready_i = 1'b0;
        set_result(3'd1, 32'hCAFE_0001, 5'd2, 1'b1, 1'b0, 6'd0);
        tick();
        clear_result();
        n_checks++; if (wb_valid_o !== 1'b1) begin n_fail++; $display("FAIL pending_write: got %b expected 1", wb_valid_o); end
        #2;
        async_rst_ni = 1'b0;
        #1;
        n_checks++; if (wb_valid_o !== 1'b0 || proto_err_o !== 1'b0 || issue_ready_o !== 1'b1)
            begin n_fail++; $display("FAIL async_reset: got wb=%b err=%b ir=%b expected 0/0/1", wb_valid_o, proto_err_o, issue_ready_o); end
        #3;
        async_rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        clear_result();
        rif.id = '0; rif.data = '0; rif.rd = '0; rif.exccode = '0;
        #12;
        async_rst_ni = 1'b1;
        tick();
        test_reset();
        test_in_order();
        test_out_of_order();
        test_kill();
        test_exception();
        test_full_backpressure();
        test_proto_err_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
